// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: registered bitwise gate (AND/OR/XOR/NAND) behind a
// valid/ready handshake. It also reports a per-bit change mask against the
// previously delivered result and keeps a saturating count of changed results.
module logic_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] chg_mask,
  output logic [CNT_W-1:0] chg_cnt,
  input  logic             clr_cnt
);

  localparam logic [1:0]       OP_AND  = 2'd0;
  localparam logic [1:0]       OP_OR   = 2'd1;
  localparam logic [1:0]       OP_XOR  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             accept;
  logic             consume;
  logic [WIDTH-1:0] f_val;
  logic [WIDTH-1:0] c_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] mask_next;
  logic [WIDTH-1:0] prev_reg;
  logic             out_valid_reg;
  logic             out_valid_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Single-entry output register: a slot is free when empty or being drained.
  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_reg && out_ready;

  // Per-bit gate; NAND is the fall-through encoding.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign f_val[gi] = (op == OP_AND) ? (a[gi] & b[gi]) :
                       (op == OP_OR)  ? (a[gi] | b[gi]) :
                       (op == OP_XOR) ? (a[gi] ^ b[gi]) :
                                        ~(a[gi] & b[gi]);
  end

  assign mask_next = f_val ^ prev_reg;

  // Output-valid next state: a new beat keeps it set, a bare drain clears it.
  always_comb begin
    out_valid_next = out_valid_reg;
    if (accept) begin
      out_valid_next = 1'b1;
    end else if (consume) begin
      out_valid_next = 1'b0;
    end
  end

  // Change counter next state: clear has priority, otherwise saturating +1.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr_cnt) begin
      cnt_next = '0;
    end else if (accept && (mask_next != '0) && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + CNT_ONE;
    end
  end

  // State registers; reset drops any pending beat immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      c_reg         <= '0;
      mask_reg      <= '0;
      prev_reg      <= '0;
      cnt_reg       <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      cnt_reg       <= cnt_next;
      if (accept) begin
        c_reg    <= f_val;
        mask_reg <= mask_next;
        prev_reg <= f_val;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign c         = c_reg;
  assign chg_mask  = mask_reg;
  assign chg_cnt   = cnt_reg;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Testbench for logic_gate_pipe: a wide instance (WIDTH=8, CNT_W=3) and a
// narrow instance (WIDTH=1, CNT_W=2) checked against a behavioural model.
module tb_logic_gate_pipe;

  logic clk;
  logic rst;

  // Wide instance signals
  logic       in_valid, in_ready, out_valid, out_ready, clr_cnt;
  logic [7:0] a, b, c, chg_mask;
  logic [1:0] op;
  logic [2:0] chg_cnt;

  // Narrow instance signals
  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_clr_cnt;
  logic [0:0] s_a, s_b, s_c, s_chg_mask;
  logic [1:0] s_op;
  logic [1:0] s_chg_cnt;

  int checks = 0;
  int errors = 0;

  // Model state, index 0 = wide, 1 = narrow
  logic [7:0] m_c    [2];
  logic [7:0] m_mask [2];
  logic       m_valid[2];
  int         m_cnt  [2];

  logic [7:0] tt_c    [4];
  logic [7:0] tt_mask [4];

  logic_gate_pipe #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .chg_mask(chg_mask), .chg_cnt(chg_cnt), .clr_cnt(clr_cnt)
  );

  logic_gate_pipe #(.WIDTH(1), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .op(s_op),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .c(s_c), .chg_mask(s_chg_mask), .chg_cnt(s_chg_cnt), .clr_cnt(s_clr_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gate(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_c[i] = 8'h00; m_mask[i] = 8'h00; m_valid[i] = 1'b0; m_cnt[i] = 0;
    end
  endfunction

  task automatic check_outputs(input int s, input string tag);
    if (s == 0) begin
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid[0]));
      chk({tag, ".c"},         32'(c),         32'(m_c[0]));
      chk({tag, ".chg_mask"},  32'(chg_mask),  32'(m_mask[0]));
      chk({tag, ".chg_cnt"},   32'(chg_cnt),   32'(m_cnt[0]));
    end else begin
      chk({tag, ".s_out_valid"}, 32'(s_out_valid), 32'(m_valid[1]));
      chk({tag, ".s_c"},         32'(s_c),         32'(m_c[1]));
      chk({tag, ".s_chg_mask"},  32'(s_chg_mask),  32'(m_mask[1]));
      chk({tag, ".s_chg_cnt"},   32'(s_chg_cnt),   32'(m_cnt[1]));
    end
  endtask

  // One clock cycle on instance s (0 wide, 1 narrow); the other instance idles.
  // Entered and left just after a rising edge.
  task automatic cycle(input int s, input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [1:0] iop, input logic ordy, input logic clr, input string tag);
    logic [7:0] wm;
    logic [7:0] r;
    logic       acc;
    int         cmax;
    wm   = (s == 0) ? 8'hFF : 8'h01;
    cmax = (s == 0) ? 7 : 3;
    in_valid = 1'b0; clr_cnt = 1'b0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_clr_cnt = 1'b0; s_out_ready = 1'b0;
    if (s == 0) begin
      in_valid = iv; a = ia; b = ib; op = iop; out_ready = ordy; clr_cnt = clr;
    end else begin
      s_in_valid = iv; s_a = ia[0]; s_b = ib[0]; s_op = iop; s_out_ready = ordy; s_clr_cnt = clr;
    end
    #1;
    chk({tag, ".in_ready"}, 32'((s == 0) ? in_ready : s_in_ready), 32'(!m_valid[s] || ordy));
    acc = iv && (!m_valid[s] || ordy);
    @(posedge clk);
    if (acc) begin
      r = gate(ia, ib, iop) & wm;
      m_mask[s] = r ^ m_c[s];
      if (m_mask[s] != 8'h00 && m_cnt[s] < cmax) m_cnt[s]++;
      m_c[s] = r;
      m_valid[s] = 1'b1;
    end else if (m_valid[s] && ordy) begin
      m_valid[s] = 1'b0;
    end
    if (clr) m_cnt[s] = 0;
    #1;
    check_outputs(s, tag);
    $display("[%0t] %s dut=%0d acc=%0b c=%02h mask=%02h cnt=%0d",
             $time, tag, s, acc, m_c[s], m_mask[s], m_cnt[s]);
  endtask

  // Assert reset between edges and confirm both instances clear without a clock.
  task automatic async_reset(input string tag);
    in_valid = 1'b0; clr_cnt = 1'b0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_clr_cnt = 1'b0; s_out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs(0, tag);
    check_outputs(1, tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(1));
    chk({tag, ".s_in_ready"}, 32'(s_in_ready), 32'(1));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    $display("[%0t] %s reset released", $time, tag);
  endtask

  initial begin
    tt_c[0] = 8'hC0; tt_c[1] = 8'hFC; tt_c[2] = 8'h3C; tt_c[3] = 8'h3F;
    tt_mask[0] = 8'hC0; tt_mask[1] = 8'h3C; tt_mask[2] = 8'hC0; tt_mask[3] = 8'h03;
    rst = 1'b1;
    in_valid = 1'b0; a = 8'h00; b = 8'h00; op = 2'd0; out_ready = 1'b0; clr_cnt = 1'b0;
    s_in_valid = 1'b0; s_a = 1'b0; s_b = 1'b0; s_op = 2'd0; s_out_ready = 1'b0; s_clr_cnt = 1'b0;
    model_reset();
    #3;
    check_outputs(0, "reset");
    check_outputs(1, "reset");
    chk("reset.in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Truth table on consecutive cycles
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1'b1, 8'hF0, 8'hCC, 2'(k), 1'b1, 1'b0, "tt");
      chk("tt.c_const", 32'(c), 32'(tt_c[k]));
      chk("tt.mask_const", 32'(chg_mask), 32'(tt_mask[k]));
    end
    chk("tt.cnt_const", 32'(chg_cnt), 32'(4));
    cycle(0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, "tt_drain");

    // Sensitivity sweep on the 1-bit AND
    cycle(1, 1'b1, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, "sweep00");
    cycle(1, 1'b1, 8'h01, 8'h00, 2'd0, 1'b1, 1'b0, "sweep10");
    cycle(1, 1'b1, 8'h01, 8'h01, 2'd0, 1'b1, 1'b0, "sweep11");
    cycle(1, 1'b1, 8'h00, 8'h01, 2'd0, 1'b1, 1'b0, "sweep01");
    chk("sweep.cnt_const", 32'(s_chg_cnt), 32'(2));
    cycle(1, 1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, "sweep_drain");

    // Backpressure: hold 0x0F for 5 cycles while operands churn
    cycle(0, 1'b1, 8'hFF, 8'h0F, 2'd0, 1'b0, 1'b0, "bp_acc");
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'b0, 1'b0, "bp_hold");
      chk("bp.c_const", 32'(c), 32'h0F);
      chk("bp.in_ready_const", 32'(in_ready), 32'(0));
    end
    cycle(0, 1'b1, 8'h33, 8'h0F, 2'd1, 1'b1, 1'b0, "bp_release");
    chk("bp.next_const", 32'(c), 32'h3F);
    cycle(0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, "bp_drain");

    // Repeated identical result counts once
    for (int k = 0; k < 3; k++) cycle(0, 1'b1, 8'h55, 8'hAA, 2'd2, 1'b1, 1'b0, "repeat");
    chk("repeat.mask_const", 32'(chg_mask), 32'h00);

    // Saturation and clear-wins on both instances
    for (int k = 0; k < 10; k++) cycle(0, 1'b1, (k % 2 == 0) ? 8'h01 : 8'h02, 8'h00, 2'd1, 1'b1, 1'b0, "sat");
    chk("sat.cnt_const", 32'(chg_cnt), 32'(7));
    cycle(0, 1'b1, 8'h01, 8'h00, 2'd1, 1'b1, 1'b1, "sat_clr");
    chk("sat_clr.cnt_const", 32'(chg_cnt), 32'(0));
    for (int k = 0; k < 5; k++) cycle(1, 1'b1, 8'((k + 1) % 2), 8'h01, 2'd0, 1'b1, 1'b0, "s_sat");
    chk("s_sat.cnt_const", 32'(s_chg_cnt), 32'(3));
    cycle(1, 1'b1, 8'h00, 8'h01, 2'd0, 1'b1, 1'b1, "s_sat_clr");
    chk("s_sat_clr.cnt_const", 32'(s_chg_cnt), 32'(0));

    // Randomized traffic on both instances
    for (int k = 0; k < 300; k++) begin
      cycle(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
            2'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), "rand");
    end

    // Asynchronous reset while a 0x3C beat is held
    cycle(0, 1'b1, 8'hF0, 8'hCC, 2'd2, 1'b1, 1'b0, "pre_rst");
    chk("pre_rst.c_const", 32'(c), 32'h3C);
    async_reset("async_rst");
    cycle(0, 1'b1, 8'hF0, 8'hCC, 2'd2, 1'b1, 1'b0, "post_rst");
    chk("post_rst.mask_const", 32'(chg_mask), 32'h3C);
    chk("post_rst.cnt_const", 32'(chg_cnt), 32'(1));
    cycle(0, 1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, "final_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_gate_pipe.md
Name: logic_gate_pipe

Overview:
Parametrised successor to the combinational 2-input AND gate. Applies a runtime-selected bitwise operation (AND/OR/XOR/NAND) to two WIDTH-bit operands. The result is registered behind a valid/ready handshake. The block also tracks output sensitivity: a per-bit change mask against the previously delivered result, and a saturating count of results that changed. Used in gate-level bring-up benches and as a reusable registered logic stage.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
CNT_W, 16, width of the change counter (>=2)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset; asynchronous, active-high
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept operand beat
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  2  operation: 0=AND, 1=OR, 2=XOR, 3=NAND
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
c  output  WIDTH  registered result
chg_mask  output  WIDTH  c XOR previous accepted result, registered with c
chg_cnt  output  CNT_W  number of accepted inputs whose result differed from the previous one; saturating
clr_cnt  input  1  synchronous clear of chg_cnt

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - out_valid=0, c=0, chg_mask=0, chg_cnt=0
  - internal prev-result register=0
  - in_ready=1 once out_valid=0
- Result function per bit: AND a&b; OR a|b; XOR a^b; NAND ~(a&b). op is sampled together with a/b on acceptance.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, 1-entry output register)
  - Input accepted on a rising edge with in_valid && in_ready.
  - Output consumed on a rising edge with out_valid && out_ready.
- Latency: exactly 1 cycle. A beat accepted at edge N presents c at edge N, visible in cycle N+1.
- On acceptance:
  - c <= f(a,b,op)
  - chg_mask <= f(a,b,op) ^ prev
  - prev <= f(a,b,op)
  - out_valid <= 1
- Consume without new accept: out_valid <= 0. c and chg_mask hold their last value.
- Simultaneous consume and accept in the same cycle: out_valid stays 1 and c updates (full throughput, one beat/cycle).
- Backpressure: while out_valid=1 and out_ready=0:
  - c, chg_mask and out_valid hold
  - in_ready=0
  - a/b/op are ignored
- in_valid must not depend on in_ready. out_valid must not drop without a consume.
- chg_cnt:
  - Increments by 1 on each acceptance where chg_mask_next != 0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - clr_cnt=1 sets chg_cnt to 0 on that edge. If it coincides with a counting acceptance, clear wins (result 0). prev/c still update normally.
- The first accepted beat after reset compares against prev=0. A nonzero result therefore counts as a change.
- Reset mid-operation: any pending out_valid beat is discarded, all state returns to reset values, and nothing is delivered.

Test Plan:
1. Truth table, WIDTH=8, out_ready=1: a=0xF0, b=0xCC, op=0..3 on consecutive cycles -> c=0xC0, 0xFC, 0x3C, 0x3F one cycle after each accept. chg_mask=0xC0, 0x3C, 0xC0, 0x03. chg_cnt ends at 4.
2. Sensitivity sweep (2-input AND, WIDTH=1): (a,b)=(0,0),(1,0),(1,1),(0,1) -> c=0,0,1,0. chg_mask=0,0,1,1. chg_cnt=2.
3. Backpressure: out_ready=0 after first accept of a=0xFF, b=0x0F, AND -> c holds 0x0F and in_ready=0 for 5 cycles while a/b change. Releasing out_ready delivers 0x0F exactly once, then the next beat.
4. Repeat result: same a=0x55, b=0xAA, XOR accepted 3 times -> c=0xFF each time. chg_mask=0xFF then 0x00, 0x00. chg_cnt increments by 1 only.
5. Saturation/clear, CNT_W=2: 5 alternating results 0x01/0x02 -> chg_cnt stops at 3. clr_cnt asserted together with a changing accept -> chg_cnt=0 next cycle.
6. Async reset mid-stream: assert rst between edges while out_valid=1, c=0x3C -> out_valid, c, chg_cnt go to 0 immediately without waiting for clk. First post-reset beat 0x3C reports chg_mask=0x3C.
